urng_packer: RTL and testbench

Downstream stage of the Tausworthe uniform generator in the AWGN chain. It consumes successive 32-bit `taus` output words and packs each pair into the 48-bit `u0` and 16-bit `u1` uniform operands of the Box-Muller datapath. It drives the generator's advance enable, buffers packed pairs in a small first-word-fall-through FIFO, and presents them on a valid/ready interface. When the consumer stalls, it back-pressures the generator so no word is lost or duplicated.

---
 rtl/urng_packer_pkg.sv | 32 +++
 rtl/urng_pair_fifo.sv | 76 +++++++
 rtl/urng_packer.sv | 129 ++++++++++++
 tb/tb_urng_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/urng_packer_pkg.sv
// urng_packer_pkg
// Shared types and constants for the AWGN uniform-operand packer.
//   U0_W / U1_W / TAUS_W : operand and generator word widths
//   state_t              : packer FSM state
//   pair_t               : packed {u0, u1} pair as stored in the pair FIFO
//   pack_pair()          : forms a pair from two successive generator words
package urng_packer_pkg;

  localparam int U0_W   = 48;
  localparam int U1_W   = 16;
  localparam int TAUS_W = 32;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  typedef struct packed {
    logic [U0_W-1:0] u0;
    logic [U1_W-1:0] u1;
  } pair_t;

  // a is the earlier word; b's upper half extends u0, its lower half is u1.
  function automatic pair_t pack_pair(input logic [TAUS_W-1:0] a,
                                      input logic [TAUS_W-1:0] b);
    pair_t p;
    p.u0 = {a, b[TAUS_W-1:U1_W]};
    p.u1 = b[U1_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/urng_pair_fifo.sv
// urng_pair_fifo
// First-word-fall-through FIFO of packed pairs with same-cycle push/pop.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   push       : write wr_data (ignored when full unless popping same cycle)
//   wr_data    : pair to store
//   pop        : consume the head (ignored when empty)
//   rd_data    : current head, reads 0 when empty
//   full/empty : occupancy flags
// DEPTH must be a power of 2 and >= 2 so pointers wrap by natural overflow.
module urng_pair_fifo
  import urng_packer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  pair_t wr_data,
  input  logic  pop,
  output pair_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  pair_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // When full, a write is only legal because the head leaves on the same
  // edge; wr_ptr then equals rd_ptr and overwrites the consumed slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head depends only on registered state, never on pop in the same cycle;
  // a fresh push into an empty FIFO appears one edge later.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/urng_packer.sv
// urng_packer
// Packs successive 32-bit Tausworthe words into {u0[47:0], u1[15:0]} pairs,
// buffers them in a small FWFT FIFO and back-pressures the generator.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   taus_out   : current generator word, consumed on edges where taus_en=1
//   taus_en    : generator advance request
//   u0, u1     : FIFO head operands (0 when empty)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts head when out_valid & out_ready
//   zero_cnt   : count of u0==0 substitutions (only with zero guard)
// Optional feature macro: URNG_PACKER_ZERO_GUARD_EN -- replaces a packed
// u0 of zero by 1 and counts the substitutions (saturating).
module urng_packer
  import urng_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAUS_W-1:0] taus_out,
  output logic              taus_en,
  output logic [U0_W-1:0]   u0,
  output logic [U1_W-1:0]   u1,
  output logic              out_valid,
  input  logic              out_ready
`ifdef URNG_PACKER_ZERO_GUARD_EN
  ,
  output logic [15:0]       zero_cnt
`endif
);

  state_t            state_reg;
  logic [TAUS_W-1:0] a_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  pair_t             pair_raw;
  pair_t             pair_wr;
  pair_t             pair_head;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // In S_SECOND the generator may only advance if the pair has somewhere to
  // go: free space now, or a slot freed by a pop on the same edge.
  always_comb begin
    taus_en = 1'b0;
    if (rst_n) begin
      if (state_reg == S_FIRST) begin
        taus_en = 1'b1;
      end else begin
        taus_en = ~fifo_full | pop;
      end
    end
  end

  assign push     = taus_en & (state_reg == S_SECOND);
  assign pair_raw = pack_pair(a_reg, taus_out);

`ifdef URNG_PACKER_ZERO_GUARD_EN
  logic        zero_hit;
  logic [15:0] zero_cnt_reg;

  // ln(u0) downstream cannot take zero, so the smallest nonzero value is used.
  always_comb begin
    pair_wr  = pair_raw;
    zero_hit = (pair_raw.u0 == '0);
    if (zero_hit) begin
      pair_wr.u0 = U0_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_cnt_reg <= '0;
    end else if (push && zero_hit && (zero_cnt_reg != 16'hFFFF)) begin
      zero_cnt_reg <= zero_cnt_reg + 16'd1;
    end
  end

  assign zero_cnt = zero_cnt_reg;
`else
  assign pair_wr = pair_raw;
`endif

  // Word A waits in a_reg; S_SECOND simply holds while the FIFO cannot take
  // the pair, so the generator word B stays on taus_out untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_FIRST;
      a_reg     <= '0;
    end else begin
      case (state_reg)
        S_FIRST: begin
          if (taus_en) begin
            a_reg     <= taus_out;
            state_reg <= S_SECOND;
          end
        end
        S_SECOND: begin
          if (taus_en) begin
            state_reg <= S_FIRST;
          end
        end
        default: state_reg <= S_FIRST;
      endcase
    end
  end

  urng_pair_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_data(pair_wr),
    .pop    (pop),
    .rd_data(pair_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign u0 = pair_head.u0;
  assign u1 = pair_head.u1;

endmodule

// File: tb/tb_urng_packer.sv
// tb_urng_packer
// Directed bench for urng_packer (FIFO_DEPTH=2). A generator model replays a
// short word table, then counts up; a scoreboard queue holds expected
// {u0,u1} pairs and a negedge monitor checks every accepted head.
// Builds with or without URNG_PACKER_ZERO_GUARD_EN.
module tb_urng_packer;

  logic        clk;
  logic        rst_n;
  logic [31:0] taus_out;
  logic        taus_en;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        out_valid;
  logic        out_ready;
`ifdef URNG_PACKER_ZERO_GUARD_EN
  logic [15:0] zero_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  int sb_pops = 0;

  // generator model
  logic [31:0] gen_tab [2];
  int          gen_tab_len;
  logic [31:0] gen_base;
  int          gen_idx;
  logic        gen_restart;

  logic [63:0] exp_q [$];

  urng_packer #(.FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .taus_out (taus_out),
    .taus_en  (taus_en),
    .u0       (u0),
    .u1       (u1),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef URNG_PACKER_ZERO_GUARD_EN
    ,
    .zero_cnt (zero_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gen_restart) gen_idx <= 0;
    else if (taus_en) gen_idx <= gen_idx + 1;
  end

  always_comb begin
    if (gen_idx < gen_tab_len) taus_out = gen_tab[gen_idx];
    else taus_out = gen_base + 32'(gen_idx - gen_tab_len);
  end

  // scoreboard monitor: head is accepted on the next edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      sb_pops++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h required <none>", {u0, u1});
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({u0, u1} !== e) begin
          errors++;
          $display("FAIL sb_pair: got %h required %h", {u0, u1}, e);
        end else begin
          $display("pop  u0=%h u1=%h", u0, u1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({a, b});
  endtask

  // Returns just after the last reset edge; the next edge is E0.
  task automatic apply_reset();
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    gen_restart = 1'b1;
    step();
    step();
    sample();
    chk("rst_taus_en", 64'(taus_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_head", {u0, u1}, 64'd0);
`ifdef URNG_PACKER_ZERO_GUARD_EN
    chk("rst_zero_cnt", 64'(zero_cnt), 64'd0);
`endif
    exp_q.delete();
    step();
    rst_n       = 1'b1;
    gen_restart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    gen_restart = 1'b1;
    gen_tab[0]  = 32'h0;
    gen_tab[1]  = 32'h0;
    gen_tab_len = 0;
    gen_base    = 32'd1;

    // directed first pair and out_valid timing
    gen_tab[0] = 32'h12345678;
    gen_tab[1] = 32'h9ABCDEF0;
    gen_tab_len = 2;
    gen_base = 32'd0;
    apply_reset();
    step();                                  // E0
    sample();
    chk("valid_after_E0", 64'(out_valid), 64'd0);
    step();                                  // E1
    sample();
    chk("valid_after_E1", 64'(out_valid), 64'd1);
    chk("first_head", {u0, u1}, 64'h123456789ABC_DEF0);
`ifdef URNG_PACKER_ZERO_GUARD_EN
    chk("zero_cnt_nonzero", 64'(zero_cnt), 64'd0);
`endif

    // zero u0 case
    gen_tab[0] = 32'h00000000;
    gen_tab[1] = 32'h0000FFFF;
    apply_reset();
    step();
    step();
    sample();
`ifdef URNG_PACKER_ZERO_GUARD_EN
    chk("zero_guard_head", {u0, u1}, 64'h000000000001_FFFF);
    chk("zero_cnt_one", 64'(zero_cnt), 64'd1);
`else
    chk("zero_pass_head", {u0, u1}, 64'h000000000000_FFFF);
`endif

    // counter generator, consumer always ready: steady 1 pair / 2 cycles
    gen_tab_len = 0;
    gen_base = 32'd1;
    apply_reset();
    for (int j = 0; j < 30; j++) push_exp(32'(2*j+1), 32'(2*j+2));
    out_ready = 1'b1;
    repeat (4) step();
    p0 = sb_pops;
    repeat (20) step();
    chk("throughput_pops_20cyc", 64'(sb_pops - p0), 64'd10);
    out_ready = 1'b0;

    // stall: FIFO fills, generator stops after third A
    apply_reset();
    for (int j = 0; j < 14; j++) push_exp(32'(2*j+1), 32'(2*j+2));
    p0 = sb_pops;
    repeat (20) step();
    sample();
    chk("stall_gen_idx", 64'(gen_idx), 64'd5);
    chk("stall_taus_en", 64'(taus_en), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_head", {u0, u1}, 64'h000000010000_0002);
    step();
    out_ready = 1'b1;
    sample();
    chk("full_ready_taus_en", 64'(taus_en), 64'd1);
    step();                                  // push (5,6) + pop (1,2)
    out_ready = 1'b0;
    sample();
    chk("after_pushpop_taus_en", 64'(taus_en), 64'd1);
    chk("after_pushpop_head", {u0, u1}, 64'h000000030000_0004);
    step();                                  // A=7 captured
    sample();
    chk("still_full_taus_en", 64'(taus_en), 64'd0);
    chk("still_full_gen_idx", 64'(gen_idx), 64'd7);
    step();
    out_ready = 1'b1;
    repeat (12) step();
    out_ready = 1'b0;
    chk("stall_release_pops_min", 64'(sb_pops - p0 >= 5), 64'd1);

    // reset pulse in S_SECOND with occupancy 1
    apply_reset();
    step();                                  // A=1
    step();                                  // push (1,2)
    step();                                  // A=3, S_SECOND
    rst_n = 1'b0;
    sample();
    chk("rst_pulse_taus_en", 64'(taus_en), 64'd0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    step();                                  // reset edge
    rst_n = 1'b1;
    sample();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_gen_idx", 64'(gen_idx), 64'd3);
    step();                                  // A=4
    step();                                  // push (4,5)
    sample();
    chk("post_rst_valid_pair", 64'(out_valid), 64'd1);
    chk("post_rst_head", {u0, u1}, 64'h000000040000_0005);
    for (int j = 0; j < 6; j++) push_exp(32'(2*j+4), 32'(2*j+5));
    step();
    out_ready = 1'b1;
    repeat (10) step();
    out_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
